wvb_reader: RTL and testbench
=============================

// Module: wvb_reader
// PURPOSE
//  Drains the waveform buffer, one event at a time. It pops a header and reads the event's samples from storage.
//  It then streams the event as 32-bit words over a valid/ready interface to the readout FIFO and releases the buffer space.
//  Sits between waveform buffer storage (with its read-address and overflow controllers) and the DAQ readout path.
// PARAMETERS
//  P_DATA_WIDTH  22  sample width {tot, discr[7:0], adc[11:0]}
//  P_ADR_WIDTH   12  waveform buffer address width
//  P_HDR_WIDTH   80  header width
//  P_LTC_WIDTH   48  timestamp width
//  P_RD_LAT       2  cycles from wvb_rdreq to sample valid on wvb_data
//  P_SKID_DEPTH   4  sample skid FIFO depth (power of 2, >= P_RD_LAT+1)
// PORTS
//  clk         in   1   system clock
//  rst         in   1   reset, asynchronous, active-low
//  rd_en       in   1   permit starting new events
//  hdr_empty   in   1   header FIFO empty (first-word-fall-through)
//  hdr_data    in   80  header at FIFO head
//  hdr_rdreq   out  1   1-cycle pop of header FIFO
//  wvb_data    in   22  sample read data
//  wvb_rdreq   out  1   1-cycle read strobe; address advances after each strobe
//  wvb_rddone  out  1   1-cycle pulse: event fully read, space released
//  dout        out  32  output word
//  dout_valid  out  1   dout valid
//  dout_last   out  1   last word of event, qualified by dout_valid
//  dout_ready  in   1   downstream accepts when valid&&ready
//  busy        out  1   FSM not IDLE
//  evt_cnt     out  16  events completed, wraps at 0xFFFF->0
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; skid FIFO and credits cleared; evt_cnt=0.
//  Header fields: ltc[47:0], start_addr[59:48], stop_addr[71:60], trig_src[73:72], cnst_run[74], overflow[75], rsvd[79:76].
//  nsamp[12:0] = ((stop-start) mod 2^12) + 1, range 1..4096. stop==start-1 means full depth, 4096.
//  FSM IDLE: if rd_en && !hdr_empty, latch hdr_data, pulse hdr_rdreq the same cycle, go to H0.
//  FSM H0: emits W0 = {8'hA5, trig_src, cnst_run, overflow, 7'b0, nsamp}. Advance on accept.
//  FSM H1: emits W1 = ltc[47:16]. Advance on accept.
//  FSM H2: emits W2 = {ltc[15:0], 16'h0000}. Advance on accept, go to SAMP.
//  FSM SAMP: emits one word per sample, {10'b0, sample}, in address order.
//  FSM SAMP: dout_last on the nsamp-th sample word. On its accept go to DONE.
//  FSM DONE: pulse wvb_rddone for 1 cycle, evt_cnt++, go to IDLE.
//  A new header may pop on the cycle after DONE.
//  Reads: first wvb_rdreq no earlier than 1 cycle after hdr_rdreq. Reads may be issued while in H0..SAMP.
//  Reads are credit-limited: issue only if (in-flight + skid occupancy) < P_SKID_DEPTH.
//  Exactly nsamp strobes are issued per event.
//  Each wvb_data is captured into the skid FIFO P_RD_LAT cycles after its strobe (shift-register tag).
//  No sample is ever dropped under backpressure.
//  dout and dout_last are held stable while dout_valid && !dout_ready. dout_valid is never retracted without accept.
//  Simultaneous capture and pop of the skid FIFO is legal at any occupancy.
//  rd_en deasserted mid-event: the current event completes; no new pop follows.
//  Reset mid-event: immediate clear. The popped header is discarded; the whole buffer is reset with it.
//  Registered outputs only. No combinational path from dout_ready to dout_valid.
// STRUCTURE
//  Shared include wvb_hdr_defs.vh holds:
//   - header field bit positions
//   - sync byte 8'hA5
//   - FSM state encodings
//   - reused by the waveform buffer writer.
//  One sub-module, wvb_rd_skid_fifo: P_SKID_DEPTH x 22 register FIFO with count output.
// TESTING
//  T1: start=0x000, stop=0x003, ltc=0x123456789ABC, trig_src=2, ready=1.
//      -> 0xA5800004, 0x12345678, 0x9ABC0000, then 4 samples; last flagged; 1 rddone; evt_cnt=1.
//  T2: start=0xFFE, stop=0x001.
//      -> nsamp=4; addresses read FFE, FFF, 000, 001 in order.
//  T3: start=0x005, stop=0x004.
//      -> W0 nsamp field 0x1000; 4096 sample words; exactly 4096 wvb_rdreq.
//  T4: T1 event with dout_ready random (30% low).
//      -> word stream identical to T1; in-flight+occupancy never exceeds 4; dout stable while stalled.
//  T5: two headers queued, ready=1.
//      -> two complete events; rddone pulses twice; second hdr_rdreq 1 cycle after first DONE; evt_cnt=2.
//  T6: rst low during sample 2 of 8, then release with hdr_empty=1.
//      -> all outputs 0 asynchronously; FSM stays IDLE; no rddone emitted.

Source files
------------

// File: rtl/wvb_reader_pkg.sv
// Shared waveform-buffer header layout, sync byte, reader FSM states and W0 helpers.
// Reused by the waveform buffer writer so both sides agree on the header format.
package wvb_reader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // 80-bit header, MSB first: rsvd[79:76] .. ltc[47:0]
  typedef struct packed {
    logic [3:0]  rsvd;
    logic        overflow;
    logic        cnst_run;
    logic [1:0]  trig_src;
    logic [11:0] stop_addr;
    logic [11:0] start_addr;
    logic [47:0] ltc;
  } hdr_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_H0   = 3'd1,
    ST_H1   = 3'd2,
    ST_H2   = 3'd3,
    ST_SAMP = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  // stop == start-1 wraps to the full 4096-sample depth
  function automatic logic [12:0] calc_nsamp(input logic [11:0] start_addr,
                                             input logic [11:0] stop_addr);
    logic [11:0] diff;
    diff = stop_addr - start_addr;
    return {1'b0, diff} + 13'd1;
  endfunction

  function automatic logic [31:0] make_w0(input hdr_t h, input logic [12:0] nsamp);
    return {SYNC_BYTE, h.trig_src, h.cnst_run, h.overflow, 7'b0, nsamp};
  endfunction

endpackage

// File: rtl/wvb_reader_skid_fifo.sv
// Register FIFO that absorbs waveform samples returning from storage while dout stalls.
// Push and pop in the same cycle are accepted at any occupancy, including full.
module wvb_rd_skid_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 22,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_dat,
  output logic [AW:0]      cnt
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             push;
  logic             pop;

  assign pop    = rd_en && (cnt != '0);
  assign push   = wr_en && ((cnt != (AW+1)'(DEPTH)) || pop);
  assign rd_dat = mem[rptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wr_dat;
  end

endmodule

// File: rtl/wvb_reader.sv
// Pops one header, reads its samples from the waveform buffer and streams 3 header words plus samples.
// Storage reads are credit-limited so returning samples always fit in the skid FIFO.
module wvb_reader
  import wvb_reader_pkg::*;
#(
  parameter int P_DATA_WIDTH = 22,
  parameter int P_ADR_WIDTH  = 12,
  parameter int P_HDR_WIDTH  = 80,
  parameter int P_LTC_WIDTH  = 48,
  parameter int P_RD_LAT     = 2,
  parameter int P_SKID_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rd_en,
  input  logic                    hdr_empty,
  input  logic [P_HDR_WIDTH-1:0]  hdr_data,
  output logic                    hdr_rdreq,
  input  logic [P_DATA_WIDTH-1:0] wvb_data,
  output logic                    wvb_rdreq,
  output logic                    wvb_rddone,
  output logic [31:0]             dout,
  output logic                    dout_valid,
  output logic                    dout_last,
  input  logic                    dout_ready,
  output logic                    busy,
  output logic [15:0]             evt_cnt
);

  localparam int CW = $clog2(P_SKID_DEPTH) + 1;

  state_t                   state_q, state_d;
  hdr_t                     hdr_in;
  logic [P_LTC_WIDTH-1:0]   ltc_q, ltc_d;
  logic [P_ADR_WIDTH:0]     nsamp_in;
  logic [P_ADR_WIDTH:0]     rd_left_q, rd_left_d;
  logic [P_ADR_WIDTH:0]     out_left_q, out_left_d;
  logic [31:0]              dout_d;
  logic                     vld_d, last_d, rdreq_d, done_d;
  logic [15:0]              evt_d;
  logic [P_RD_LAT-1:0]      tag_q;
  logic                     acc;
  logic                     fifo_pop;
  logic [P_DATA_WIDTH-1:0]  fifo_dat;
  logic [CW-1:0]            fifo_cnt;
  logic [7:0]               used;
  logic                     unused_rsvd;

  assign hdr_in      = hdr_t'(hdr_data);
  assign unused_rsvd = ^hdr_in.rsvd;
  assign nsamp_in    = calc_nsamp(hdr_in.start_addr, hdr_in.stop_addr);
  assign acc         = dout_valid && dout_ready;
  assign hdr_rdreq   = (state_q == ST_IDLE) && rd_en && !hdr_empty;
  assign busy        = (state_q != ST_IDLE);

  // Every sample not yet accepted downstream holds a credit: strobe, tag pipe, FIFO or dout
  assign used = 8'(wvb_rdreq) + 8'($countones(tag_q)) + 8'(fifo_cnt)
              + 8'((state_q == ST_SAMP) && dout_valid);

  always_comb begin
    state_d    = state_q;
    ltc_d      = ltc_q;
    dout_d     = dout;
    vld_d      = dout_valid;
    last_d     = dout_last;
    out_left_d = out_left_q;
    done_d     = 1'b0;
    evt_d      = evt_cnt;
    fifo_pop   = 1'b0;
    rdreq_d    = (state_q inside {ST_H0, ST_H1, ST_H2, ST_SAMP}) && (rd_left_q != '0)
                 && (used < 8'(P_SKID_DEPTH));
    rd_left_d  = rd_left_q - (P_ADR_WIDTH+1)'(rdreq_d);
    case (state_q)
      ST_IDLE: begin
        if (rd_en && !hdr_empty) begin
          ltc_d      = hdr_in.ltc;
          dout_d     = make_w0(hdr_in, nsamp_in);
          vld_d      = 1'b1;
          last_d     = 1'b0;
          rd_left_d  = nsamp_in;
          out_left_d = nsamp_in;
          state_d    = ST_H0;
        end
      end
      ST_H0: if (acc) begin
        dout_d  = ltc_q[P_LTC_WIDTH-1 -: 32];
        state_d = ST_H1;
      end
      ST_H1: if (acc) begin
        dout_d  = {ltc_q[15:0], 16'h0000};
        state_d = ST_H2;
      end
      ST_H2: if (acc) begin
        vld_d   = 1'b0;
        state_d = ST_SAMP;
      end
      ST_SAMP: begin
        if (acc && dout_last) begin
          vld_d   = 1'b0;
          last_d  = 1'b0;
          done_d  = 1'b1;
          evt_d   = evt_cnt + 16'd1;
          state_d = ST_DONE;
        end else if ((!dout_valid || acc) && (fifo_cnt != '0) && (out_left_q != '0)) begin
          fifo_pop   = 1'b1;
          dout_d     = {{(32-P_DATA_WIDTH){1'b0}}, fifo_dat};
          vld_d      = 1'b1;
          last_d     = (out_left_q == (P_ADR_WIDTH+1)'(1));
          out_left_d = out_left_q - (P_ADR_WIDTH+1)'(1);
        end else if (acc) begin
          vld_d = 1'b0;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      ltc_q      <= '0;
      rd_left_q  <= '0;
      out_left_q <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
      wvb_rdreq  <= 1'b0;
      wvb_rddone <= 1'b0;
      evt_cnt    <= '0;
      tag_q      <= '0;
    end else begin
      state_q    <= state_d;
      ltc_q      <= ltc_d;
      rd_left_q  <= rd_left_d;
      out_left_q <= out_left_d;
      dout       <= dout_d;
      dout_valid <= vld_d;
      dout_last  <= last_d;
      wvb_rdreq  <= rdreq_d;
      wvb_rddone <= done_d;
      evt_cnt    <= evt_d;
      tag_q[0]   <= wvb_rdreq;
      for (int i = 1; i < P_RD_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  wvb_rd_skid_fifo #(
    .DEPTH (P_SKID_DEPTH),
    .WIDTH (P_DATA_WIDTH)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (tag_q[P_RD_LAT-1]),
    .wr_dat (wvb_data),
    .rd_en  (fifo_pop),
    .rd_dat (fifo_dat),
    .cnt    (fifo_cnt)
  );

endmodule

// File: tb/tb_wvb_reader.sv
// Directed bench for wvb_reader: header FIFO + storage models, event-level expected word stream.
module tb_wvb_reader;

  logic        clk;
  logic        rst;
  logic        rd_en;
  logic        hdr_empty;
  logic [79:0] hdr_data;
  logic        hdr_rdreq;
  logic [21:0] wvb_data;
  logic        wvb_rdreq;
  logic        wvb_rddone;
  logic [31:0] dout;
  logic        dout_valid;
  logic        dout_last;
  logic        dout_ready;
  logic        busy;
  logic [15:0] evt_cnt;

  wvb_reader dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .hdr_empty(hdr_empty), .hdr_data(hdr_data),
    .hdr_rdreq(hdr_rdreq), .wvb_data(wvb_data), .wvb_rdreq(wvb_rdreq), .wvb_rddone(wvb_rddone),
    .dout(dout), .dout_valid(dout_valid), .dout_last(dout_last), .dout_ready(dout_ready),
    .busy(busy), .evt_cnt(evt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] w;
    logic        last;
    logic        samp;
  } exp_t;

  int   total = 0;
  int   bad = 0;
  exp_t expq[$];
  int   evt_model = 0;

  logic [79:0] hq [16];
  int          hp = 0;
  int          hw = 0;
  logic [11:0] rd_addr = '0;
  logic [11:0] a1 = '0;
  int          low_pct = 0;

  int   cyc = 0, pops = 0, dones = 0, strobes = 0, samp_acc = 0, last_pop_cyc = -1;
  int   pop_cyc[$];
  int   done_cyc[$];
  logic stall_prev = 1'b0;
  logic [31:0] prev_dout = '0;
  logic prev_last = 1'b0;
  int   s0, d0, p0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [21:0] samp(input logic [11:0] a);
    return {a[9:0], a ^ 12'hC3A};
  endfunction

  function automatic logic [79:0] mk_hdr(input logic [11:0] st, input logic [11:0] sp,
                                         input logic [47:0] ltc, input logic [1:0] trig,
                                         input logic cnst, input logic ovf);
    return {4'h0, ovf, cnst, trig, sp, st, ltc};
  endfunction

  // Expected words for one event, straight from the header field layout
  task automatic add_event(input logic [79:0] h);
    int   st, sp, n;
    exp_t e;
    st = int'(h[59:48]);
    sp = int'(h[71:60]);
    n  = ((sp - st + 4096) % 4096) + 1;
    e.samp = 1'b0;
    e.last = 1'b0;
    e.w = (32'hA5 << 24) | (32'(h[73:72]) << 22) | (32'(h[74]) << 21)
        | (32'(h[75]) << 20) | 32'(n);
    expq.push_back(e);
    e.w = h[47:16];
    expq.push_back(e);
    e.w = {h[15:0], 16'h0000};
    expq.push_back(e);
    for (int i = 0; i < n; i++) begin
      e.w    = 32'(samp(12'((st + i) % 4096)));
      e.samp = 1'b1;
      e.last = (i == n - 1);
      expq.push_back(e);
    end
  endtask

  task automatic push_hdr(input logic [79:0] h);
    hq[hw % 16] = h;
    add_event(h);
    hw++;
  endtask

  assign hdr_empty = (hp == hw);
  assign hdr_data  = hq[hp % 16];

  // Header FIFO pop and storage with a 2-cycle read latency and self-advancing address
  always @(posedge clk) begin
    if (hdr_rdreq) begin
      rd_addr <= hq[hp % 16][59:48];
      hp      <= hp + 1;
    end else if (wvb_rdreq) begin
      rd_addr <= rd_addr + 12'd1;
    end
    a1       <= rd_addr;
    wvb_data <= samp(a1);
  end

  initial begin
    dout_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (low_pct == 0) dout_ready = 1'b1;
      else dout_ready = ($urandom_range(0, 99) >= low_pct);
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      if (hdr_rdreq) begin
        pops++;
        last_pop_cyc = cyc;
        pop_cyc.push_back(cyc);
      end
      if (wvb_rddone) begin
        dones++;
        done_cyc.push_back(cyc);
      end
      if (wvb_rdreq) begin
        strobes++;
        chk("rd_after_pop", cyc > last_pop_cyc, 1);
        chk("credit", (strobes - samp_acc) <= 4, 1);
      end
      if (stall_prev) begin
        chk("hold_valid", dout_valid, 1);
        chk("hold_dout", dout, prev_dout);
        chk("hold_last", dout_last, prev_last);
      end
      if (dout_valid && dout_ready) begin
        chk("word_expected", expq.size() != 0, 1);
        if (expq.size() != 0) begin
          exp_t e;
          e = expq.pop_front();
          chk("word", dout, e.w);
          chk("last", dout_last, e.last);
          if (e.samp) samp_acc++;
        end
      end
      stall_prev = dout_valid && !dout_ready;
      prev_dout  = dout;
      prev_last  = dout_last;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic mark();
    s0 = strobes;
    d0 = dones;
    p0 = pops;
  endtask

  task automatic wait_evts(input int nev, input int nstr, input int budget, input string nm);
    int k;
    k = 0;
    while (dones < d0 + nev && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_done_in_time"}, dones >= d0 + nev, 1);
    repeat (3) @(negedge clk);
    evt_model += nev;
    chk({nm, "_strobes"}, strobes - s0, nstr);
    chk({nm, "_rddone"}, dones - d0, nev);
    chk({nm, "_drained"}, expq.size(), 0);
    chk({nm, "_evt_cnt"}, evt_cnt, evt_model);
    chk({nm, "_idle"}, busy, 0);
  endtask

  initial begin
    int k;
    rst   = 1'b0;
    rd_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_dout", dout, 0);
    chk("rst_last", dout_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_evt_cnt", evt_cnt, 0);
    chk("rst_rdreq", wvb_rdreq, 0);
    chk("rst_rddone", wvb_rddone, 0);
    chk("rst_hdr_rdreq", hdr_rdreq, 0);
    @(negedge clk);
    rst   = 1'b1;
    rd_en = 1'b1;
    @(negedge clk);

    // T1: basic 4-sample event
    mark();
    push_hdr(mk_hdr(12'h000, 12'h003, 48'h123456789ABC, 2'd2, 1'b0, 1'b0));
    chk("t1_model_w0", expq[0].w, 32'hA5800004);
    chk("t1_model_w1", expq[1].w, 32'h12345678);
    chk("t1_model_w2", expq[2].w, 32'h9ABC0000);
    chk("t1_model_last", expq[6].last, 1);
    wait_evts(1, 4, 300, "t1");

    // T2: address wrap FFE..001, all flag bits set
    mark();
    push_hdr(mk_hdr(12'hFFE, 12'h001, 48'h000011112222, 2'd1, 1'b1, 1'b1));
    chk("t2_model_w0", expq[0].w, 32'hA5700004);
    chk("t2_model_s0", expq[3].w, 32'h003FE3C4);
    chk("t2_model_s2", expq[5].w, 32'h00000C3A);
    wait_evts(1, 4, 300, "t2");

    // T3: full-depth event
    mark();
    push_hdr(mk_hdr(12'h005, 12'h004, 48'hABCDEF012345, 2'd0, 1'b0, 1'b0));
    chk("t3_model_w0", expq[0].w, 32'hA5001000);
    wait_evts(1, 4096, 30000, "t3");

    // T4: T1 event under random backpressure
    low_pct = 30;
    mark();
    push_hdr(mk_hdr(12'h000, 12'h003, 48'h123456789ABC, 2'd2, 1'b0, 1'b0));
    wait_evts(1, 4, 1000, "t4");
    low_pct = 0;

    // rd_en dropped mid-event: current event finishes, queued header waits
    mark();
    push_hdr(mk_hdr(12'h100, 12'h103, 48'h111122223333, 2'd3, 1'b0, 1'b1));
    push_hdr(mk_hdr(12'h200, 12'h202, 48'h444455556666, 2'd1, 1'b1, 1'b0));
    k = 0;
    while (pops == p0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    rd_en = 1'b0;
    k = 0;
    while (dones == d0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    repeat (20) @(negedge clk);
    chk("rden_pops", pops - p0, 1);
    chk("rden_idle", busy, 0);
    chk("rden_dones", dones - d0, 1);
    rd_en = 1'b1;
    wait_evts(2, 7, 300, "rden");

    // T5: two queued headers, back-to-back
    mark();
    push_hdr(mk_hdr(12'h300, 12'h303, 48'h0A0B0C0D0E0F, 2'd0, 1'b1, 1'b1));
    push_hdr(mk_hdr(12'hFFF, 12'h004, 48'hFEDCBA987654, 2'd2, 1'b0, 1'b0));
    wait_evts(2, 10, 400, "t5");
    chk("t5_pops", pops - p0, 2);
    chk("t5_pop_after_done", pop_cyc[pop_cyc.size()-1] - done_cyc[done_cyc.size()-2], 1);

    // T6: asynchronous reset in the middle of an 8-sample event
    mark();
    push_hdr(mk_hdr(12'h010, 12'h017, 48'h13579BDF0246, 2'd1, 1'b0, 1'b0));
    k = samp_acc;
    while (samp_acc == k && k < 1000000) begin
      @(negedge clk);
      if (cyc > 90000) break;
    end
    chk("t6_reached_sample", samp_acc > k, 1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_dout_valid", dout_valid, 0);
    chk("t6_dout", dout, 0);
    chk("t6_last", dout_last, 0);
    chk("t6_rdreq", wvb_rdreq, 0);
    chk("t6_rddone", wvb_rddone, 0);
    chk("t6_busy", busy, 0);
    chk("t6_evt_cnt", evt_cnt, 0);
    chk("t6_hdr_rdreq", hdr_rdreq, 0);
    expq.delete();
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("t6_stays_idle", busy, 0);
    chk("t6_no_rddone", dones - d0, 0);
    chk("t6_evt_cnt_after", evt_cnt, 0);
    chk("t6_pops", pops - p0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
